// File: rtl/piso_tx_pkg.sv
// Shared types and width helpers for the framed parallel-in/serial-out transmitter.
package piso_tx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   // Never narrower than one bit, so WIDTH=1 / CLKS_PER_BIT=1 still get a real register.
   function automatic int bitcnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   function automatic int timer_w(input int clks_per_bit);
      return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
   endfunction

endpackage

// File: rtl/piso_serial_tx_bit_timer.sv
// Bit-period timer: counts enabled clocks 0..CLKS_PER_BIT-1 and ticks on the last one.
module bit_timer
   import piso_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic arst,
   input  logic en,
   input  logic clear,
   output logic tick
);

   localparam int TW = timer_w(CLKS_PER_BIT);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] timer;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         timer <= '0;
      end else if (en) begin
         if (clear || timer == LAST) timer <= '0;
         else                        timer <= timer + 1'b1;
      end
   end

   // Internal strobe only; the top registers everything it drives out.
   assign tick = en && !clear && (timer == LAST);

endmodule

// File: rtl/piso_serial_tx.sv
// Framed serial transmitter: start bit, WIDTH data bits LSB-first, stop bit.
//   state | meaning
//   IDLE  | line high, ready for a word
//   START | sending start bit (0)
//   DATA  | sending data bits, LSB first
//   STOP  | sending stop bit (1)
module piso_serial_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             en,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   output logic             tx_serial,
   output logic             tx_busy,
   output logic             tx_done
);

   localparam int CW = bitcnt_w(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   tx_state_t        state;
   logic [WIDTH-1:0] shift;
   logic [WIDTH-1:0] shift_nx;
   logic [CW-1:0]    bit_cnt;
   logic             tick;

   assign shift_nx = shift >> 1;

   // Held clear while idle so the start bit always gets a full bit period.
   bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .arst  (arst),
      .en    (en),
      .clear (state == IDLE),
      .tick  (tick)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= IDLE;
         shift     <= '0;
         bit_cnt   <= '0;
         tx_serial <= 1'b1;
         tx_ready  <= 1'b1;
         tx_busy   <= 1'b0;
         tx_done   <= 1'b0;
      end else if (en) begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (tx_valid && tx_ready) begin
                  shift     <= tx_data;
                  tx_serial <= 1'b0;
                  tx_ready  <= 1'b0;
                  tx_busy   <= 1'b1;
                  state     <= START;
               end
            end
            START: begin
               if (tick) begin
                  tx_serial <= shift[0];
                  bit_cnt   <= '0;
                  state     <= DATA;
               end
            end
            DATA: begin
               if (tick) begin
                  if (bit_cnt == LAST_BIT) begin
                     tx_serial <= 1'b1;
                     state     <= STOP;
                  end else begin
                     shift     <= shift_nx;
                     bit_cnt   <= bit_cnt + 1'b1;
                     tx_serial <= shift_nx[0];
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  tx_ready <= 1'b1;
                  tx_busy  <= 1'b0;
                  tx_done  <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serial_tx.sv
// Scoreboard bench: stimulus queues expected words, a line monitor decodes frames and compares.
module tb_piso_serial_tx;

   localparam int W   = 8;
   localparam int CPB = 4;
   localparam int NB  = W + 2;
   localparam int FL  = NB * CPB;

   logic clk = 1'b0;
   logic arst, en, tx_valid;
   logic [W-1:0] tx_data;
   logic tx_ready, tx_serial, tx_busy, tx_done;

   logic arst1, en1, valid1;
   logic [W-1:0] data1;
   logic ready1, serial1, busy1, done1;

   always #5 clk = ~clk;

   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .arst(arst), .en(en), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx_serial(tx_serial), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   piso_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .arst(arst1), .en(en1), .tx_data(data1), .tx_valid(valid1),
      .tx_ready(ready1), .tx_serial(serial1), .tx_busy(busy1), .tx_done(done1)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string name, input longint got, input longint exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   int cyc = 0;
   always @(posedge clk) cyc++;

   bit jitter = 0;
   always @(posedge clk) begin
      #1;
      if (jitter) en = ($urandom_range(0, 3) != 0);
   end

   // ---------------- scoreboard monitor ----------------
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur_exp, rx;
   bit in_frame = 0, end_pending = 0, incons, rdy_bad;
   int k, mb, frames = 0, done_cnt = 0;
   int start_cyc, last_start, last_end, prev_start, prev_end;
   int dur[NB], last_dur[NB], prev_dur[NB];

   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (arst) begin
         in_frame = 0;
         end_pending = 0;
      end else if (end_pending) begin
         end_pending = 0;
         in_frame = 0;
         chk("frame_end_ready_done_busy", {tx_ready, tx_done, tx_busy}, 3'b110);
         chk("frame_word", {incons, rdy_bad, rx}, {2'b00, cur_exp});
         prev_start = last_start; prev_end = last_end; prev_dur = last_dur;
         last_start = start_cyc; last_end = cyc; last_dur = dur;
         frames++;
      end else begin
         if (!in_frame && tx_serial === 1'b0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_frame_queue_size", exp_q.size(), 1);
               cur_exp = '0;
            end else begin
               cur_exp = exp_q.pop_front();
            end
            in_frame = 1; k = 0; incons = 0; rdy_bad = 0; rx = '0;
            dur = '{default: 0};
            start_cyc = cyc;
         end
         if (in_frame) begin
            mb = k / CPB;
            dur[mb]++;
            if (tx_ready !== 1'b0 || tx_busy !== 1'b1) rdy_bad = 1;
            if (mb == 0) begin
               if (tx_serial !== 1'b0) incons = 1;
            end else if (mb == NB - 1) begin
               if (tx_serial !== 1'b1) incons = 1;
            end else if (k % CPB == 0) begin
               rx[mb-1] = tx_serial;
            end else if (tx_serial !== rx[mb-1]) begin
               incons = 1;
            end
            if (en) begin
               k++;
               if (k == FL) end_pending = 1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [W-1:0] d);
      int t;
      t = 0;
      tx_valid = 1'b1;
      tx_data  = d;
      while (!(tx_ready && en) && t < 500) begin
         @(posedge clk); #2;
         t++;
      end
      if (t >= 500) begin
         chk("send_timeout_cycles", t, 0);
         tx_valid = 1'b0;
         return;
      end
      exp_q.push_back(d);
      @(posedge clk); #2;
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || in_frame || end_pending || !tx_ready) && t < 3000) begin
         @(posedge clk); #2;
         t++;
      end
      if (t >= 3000) chk("wait_idle_timeout_cycles", t, 0);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic chk_durs(input string name, input int stretched_bit, input int stretched_len);
      int bad;
      bad = 0;
      for (int i = 0; i < NB; i++)
         if (last_dur[i] != ((i == stretched_bit) ? stretched_len : CPB)) bad++;
      chk(name, bad, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- test sequence ----------------
   initial begin
      int d0, f0, bad, sum;
      logic [NB-1:0] exp_frame, cap;

      arst = 1; en = 1; tx_valid = 0; tx_data = '0;
      arst1 = 1; en1 = 1; valid1 = 0; data1 = '0;
      #1;
      chk("reset_outputs", {tx_serial, tx_ready, tx_busy, tx_done}, 4'b1100);
      chk("reset_outputs_cpb1", {serial1, ready1, busy1, done1}, 4'b1100);
      repeat (2) @(posedge clk);
      #2;
      arst = 0; arst1 = 0;
      repeat (2) @(posedge clk);
      #2;

      // single frame 0xA5
      d0 = done_cnt;
      send(8'hA5);
      wait_idle();
      chk("a5_frame_len", last_end - last_start, FL);
      chk("a5_done_cycles", done_cnt - d0, 1);
      chk_durs("a5_bit_durations_bad", -1, 0);

      // back-to-back 0x3C then 0xFF with tx_valid held
      d0 = done_cnt;
      send(8'h3C);
      send(8'hFF);
      wait_idle();
      sum = 0;
      for (int i = 0; i < NB; i++) sum += prev_dur[i] + last_dur[i];
      chk("b2b_bit_clocks", sum, 2 * FL);
      chk("b2b_start_after_done", last_start - prev_end, 1);
      chk("b2b_done_pulses", done_cnt - d0, 2);

      // enable stall during data bit 3 of 0x0F
      send(8'h0F);
      repeat (4 * CPB + 1) @(posedge clk);
      #2;
      en = 0;
      repeat (5) @(posedge clk);
      #2;
      en = 1;
      wait_idle();
      chk_durs("stall_bit_durations_bad", 4, CPB + 5);

      // tx_valid while busy is ignored
      f0 = frames;
      send(8'h81);
      repeat (10) @(posedge clk);
      #2;
      tx_valid = 1; tx_data = 8'h00;
      chk("busy_ready_low", tx_ready, 0);
      @(posedge clk); #2;
      tx_valid = 0;
      chk("busy_ready_still_low", tx_ready, 0);
      wait_idle();
      chk("ignore_frame_count", frames - f0, 1);

      // async reset mid-frame, then a clean frame
      f0 = frames;
      send(W'($urandom));
      repeat (15) @(posedge clk);
      #2;
      arst = 1;
      #1;
      chk("midframe_reset_outputs", {tx_serial, tx_ready, tx_busy, tx_done}, 4'b1100);
      repeat (2) @(posedge clk);
      #2;
      arst = 0;
      chk("midframe_reset_no_frame_end", frames - f0, 0);
      send(W'($urandom));
      wait_idle();

      // random words with random enable gaps
      jitter = 1;
      repeat (8) begin
         send(W'($urandom));
         repeat ($urandom_range(0, 30)) @(posedge clk);
         #2;
      end
      wait_idle();
      jitter = 0;
      #1;
      en = 1;
      wait_idle();

      // CLKS_PER_BIT=1: reset during DATA, then a clean 0x55 frame
      valid1 = 1; data1 = 8'h55;
      @(posedge clk); #2;
      valid1 = 0;
      repeat (3) @(posedge clk);
      #2;
      chk("cpb1_busy_before_reset", busy1, 1);
      arst1 = 1;
      #1;
      chk("cpb1_reset_outputs", {serial1, ready1, busy1, done1}, 4'b1100);
      repeat (2) @(posedge clk);
      #2;
      arst1 = 0;
      @(posedge clk); #2;
      valid1 = 1; data1 = 8'h55;
      @(posedge clk); #2;
      valid1 = 0;
      bad = 0;
      for (int i = 0; i < NB; i++) begin
         @(negedge clk);
         cap[i] = serial1;
         if (ready1 !== 1'b0) bad++;
      end
      exp_frame = {1'b1, 8'h55, 1'b0};
      chk("cpb1_frame_bits", cap, exp_frame);
      chk("cpb1_ready_low_cycles_bad", bad, 0);
      @(negedge clk);
      chk("cpb1_end_ready_done", {ready1, done1, serial1}, 3'b111);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
